// File: rtl/sort_host.sv
// sort_host: host-side sequencer that drives a serial nibble sorter.
//   It sends eight nibbles, starts the sort, collects the eight results and
//   checks them. On a start pulse in IDLE it latches data_word. It waits for
//   Ready, then streams nibbles 0..7 on Data_in with Load. It waits for Ready
//   again, then pulses Sort. It waits for Waiting, then pulses Send. It then
//   captures eight Data_out nibbles into result. Finally it checks that the
//   results are non-increasing and that the sum of the nibbles is preserved.
//   Each handshake wait is bounded by TIMEOUT cycles. When a wait expires the
//   job is aborted with err set.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, data_word         job request and its eight input nibbles
//   Ready, Waiting, Data_out sorter status and serial result
//   Load, Data_in, Sort, Send sorter controls (decoded from state)
//   result                   received nibbles, nibble n = n-th received
//   host_busy, done          not-IDLE flag, one-cycle end-of-job pulse
//   sorted_ok, sum_ok, err   job verdict, valid from done until next start
module sort_host #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data_word,
    input  logic        Ready,
    input  logic        Waiting,
    input  logic [3:0]  Data_out,
    output logic        Load,
    output logic [3:0]  Data_in,
    output logic        Sort,
    output logic        Send,
    output logic [31:0] result,
    output logic        host_busy,
    output logic        done,
    output logic        sorted_ok,
    output logic        sum_ok,
    output logic        err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, WAIT_RDY, LOAD, GAP, SORT, WAIT_SORT, SEND, RX, CHECK
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   buf_q;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [6:0]    tx_sum, rx_sum;
    logic          sorted_q, sum_q, err_q;
    logic          wait_st, tmo, chk, sorted_calc, sum_calc;

    assign wait_st = (state == WAIT_RDY) || (state == GAP) || (state == WAIT_SORT);

    // tmo is raised only in the cycle where the wait has expired and the
    // awaited input has still not arrived.
    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        case (state)
            IDLE:      if (start) state_nxt = WAIT_RDY;
            WAIT_RDY:  if (Ready) state_nxt = LOAD;
                       else if (cnt == TMO_MAX) begin tmo = 1'b1; state_nxt = IDLE; end
            LOAD:      if (idx == 3'd7) state_nxt = GAP;
            GAP:       if (Ready) state_nxt = SORT;
                       else if (cnt == TMO_MAX) begin tmo = 1'b1; state_nxt = IDLE; end
            SORT:      state_nxt = WAIT_SORT;
            WAIT_SORT: if (Waiting) state_nxt = SEND;
                       else if (cnt == TMO_MAX) begin tmo = 1'b1; state_nxt = IDLE; end
            SEND:      state_nxt = RX;
            RX:        if (idx == 3'd7) state_nxt = CHECK;
            CHECK:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sorted_calc = 1'b1;
        for (int n = 0; n < 7; n++)
            if (result[4*n +: 4] < result[4*(n+1) +: 4]) sorted_calc = 1'b0;
    end

    assign sum_calc  = (tx_sum == rx_sum);
    assign chk       = (state == CHECK);
    assign Load      = (state == LOAD);
    assign Sort      = (state == SORT);
    assign Send      = (state == SEND);
    assign Data_in   = Load ? buf_q[{idx, 2'b00} +: 4] : 4'd0;
    assign host_busy = (state != IDLE);
    assign done      = chk | tmo;
    assign err       = err_q | tmo;
    // In CHECK the verdict is shown live. It is then held in the registers
    // until the next accepted start.
    assign sorted_ok = chk ? sorted_calc : sorted_q;
    assign sum_ok    = chk ? sum_calc : sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            buf_q    <= '0;
            idx      <= '0;
            cnt      <= '0;
            tx_sum   <= '0;
            rx_sum   <= '0;
            result   <= '0;
            sorted_q <= 1'b0;
            sum_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            // Held at zero outside the wait states, so every wait starts from 0.
            cnt   <= wait_st ? cnt + CW'(1) : '0;
            idx   <= (state == LOAD || state == RX) ? idx + 3'd1 : 3'd0;
            if (state == IDLE && start) begin
                buf_q    <= data_word;
                result   <= '0;
                tx_sum   <= '0;
                rx_sum   <= '0;
                err_q    <= 1'b0;
                sorted_q <= 1'b0;
                sum_q    <= 1'b0;
            end
            if (state == LOAD)
                tx_sum <= tx_sum + {3'b000, buf_q[{idx, 2'b00} +: 4]};
            if (state == RX) begin
                result[{idx, 2'b00} +: 4] <= Data_out;
                rx_sum <= rx_sum + {3'b000, Data_out};
            end
            if (chk) begin
                sorted_q <= sorted_calc;
                sum_q    <= sum_calc;
            end
            if (tmo) begin
                err_q    <= 1'b1;
                sorted_q <= 1'b0;
                sum_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sort_host.sv
// Directed bench for sort_host.
// A sorter stand-in is driven from the job task. It can be correct, which
// returns the nibbles in descending order. It can be faulty in two ways: it
// returns 1..8, or it returns all zeros.
module tb_sort_host;

    logic        clk = 1'b0;
    logic        rst, start, Ready, Waiting;
    logic [31:0] data_word;
    logic [3:0]  Data_out;
    logic        Load, Sort, Send, host_busy, done, sorted_ok, sum_ok, err;
    logic [3:0]  Data_in;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    sort_host #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .data_word(data_word),
        .Ready(Ready), .Waiting(Waiting), .Data_out(Data_out),
        .Load(Load), .Data_in(Data_in), .Sort(Sort), .Send(Send),
        .result(result), .host_busy(host_busy), .done(done),
        .sorted_ok(sorted_ok), .sum_ok(sum_ok), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        logic ov;
        @(posedge clk);
        #1;
        ov = (Load & Sort) | (Load & Send) | (Sort & Send);
        chk("strobe_excl", {31'b0, ov}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] dw;
        int          mode;   // 0 good sorter, 1 returns 1..8, 2 returns zeros
        logic [31:0] exp_res;
        logic        exp_sorted;
        logic        exp_sum;
    } vec_t;

    task automatic run_job(input logic [31:0] dw, input int mode, input bit restart_rx,
                           input logic [31:0] er, input logic es, input logic esum);
        logic [3:0] sent [8];
        logic [3:0] outv [8];
        logic [3:0] t;
        bit ok;
        data_word = dw;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", {31'b0, host_busy}, 32'd1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (Load) begin ok = 1; break; end
            step();
        end
        chk("load_seen", {31'b0, ok}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("load_strobe", {31'b0, Load}, 32'd1);
            chk("data_in", {28'b0, Data_in}, {28'b0, dw[4*i +: 4]});
            sent[i] = Data_in;
            step();
        end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (Sort) begin ok = 1; break; end
            step();
        end
        chk("sort_seen", {31'b0, ok}, 32'd1);
        step(); step(); step();
        Waiting = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (Send) begin ok = 1; break; end
            step();
        end
        chk("send_seen", {31'b0, ok}, 32'd1);
        Waiting = 1'b0;
        for (int i = 0; i < 8; i++)
            outv[i] = (mode == 0) ? sent[i] : (mode == 1) ? 4'(i + 1) : 4'd0;
        if (mode == 0)
            for (int i = 0; i < 7; i++)
                for (int j = 0; j < 7 - i; j++)
                    if (outv[j] < outv[j+1]) begin
                        t = outv[j]; outv[j] = outv[j+1]; outv[j+1] = t;
                    end
        Data_out = outv[0];
        step();                              // now in RX cycle 1
        for (int m = 0; m < 8; m++) begin
            Data_out = outv[m];
            if (restart_rx && m == 3) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk("check_done", {31'b0, done}, 32'd1);
        chk("check_result", result, er);
        chk("check_sorted", {31'b0, sorted_ok}, {31'b0, es});
        chk("check_sum", {31'b0, sum_ok}, {31'b0, esum});
        chk("check_err", {31'b0, err}, 32'd0);
        step();
        chk("done_pulse_end", {31'b0, done}, 32'd0);
        chk("idle_after", {31'b0, host_busy}, 32'd0);
        chk("hold_result", result, er);
        chk("hold_sorted", {31'b0, sorted_ok}, {31'b0, es});
        chk("hold_sum", {31'b0, sum_ok}, {31'b0, esum});
        step();
        chk("stay_idle", {31'b0, host_busy}, 32'd0);
    endtask

    initial begin
        vec_t vecs [7];
        int   dc;
        bit   seen;
        vecs[0] = '{32'h87654321, 0, 32'h12345678, 1'b1, 1'b1};
        vecs[1] = '{32'h55555555, 0, 32'h55555555, 1'b1, 1'b1};
        vecs[2] = '{32'h87654321, 1, 32'h87654321, 1'b0, 1'b1};
        vecs[3] = '{32'h87654321, 2, 32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{32'h0F00A031, 0, 32'h000013AF, 1'b1, 1'b1};
        vecs[5] = '{32'h00000000, 0, 32'h00000000, 1'b1, 1'b1};
        vecs[6] = '{32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; Ready = 1'b1; Waiting = 1'b0;
        Data_out = 4'd0; data_word = 32'd0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_busy", {31'b0, host_busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'b0, sorted_ok, sum_ok, err}, 32'd0);
        chk("rst_strobes", {25'b0, Load, Sort, Send, Data_in}, 32'd0);

        for (int v = 0; v < 7; v++)
            run_job(vecs[v].dw, vecs[v].mode, 1'b0, vecs[v].exp_res,
                    vecs[v].exp_sorted, vecs[v].exp_sum);

        // Second start during RX must be ignored.
        run_job(32'h87654321, 0, 1'b1, 32'h12345678, 1'b1, 1'b1);

        // Ready held low: abort after 256 cycles in WAIT_RDY.
        Ready = 1'b0;
        data_word = 32'h87654321;
        start = 1'b1;
        step();
        start = 1'b0;
        dc = 0; seen = 0;
        for (int c = 1; c <= 300; c++) begin
            if (Load) seen = 1;
            if (done) begin dc = c; break; end
            step();
        end
        chk("tmo_cycle", 32'(dc), 32'd256);
        chk("tmo_err", {31'b0, err}, 32'd1);
        chk("tmo_sorted", {31'b0, sorted_ok}, 32'd0);
        chk("tmo_sum", {31'b0, sum_ok}, 32'd0);
        chk("tmo_no_load", {31'b0, seen}, 32'd0);
        step();
        chk("tmo_done_end", {31'b0, done}, 32'd0);
        chk("tmo_err_hold", {31'b0, err}, 32'd1);
        chk("tmo_idle", {31'b0, host_busy}, 32'd0);
        Ready = 1'b1;

        // Reset in LOAD cycle 4.
        data_word = 32'h87654321;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Load) break;
            step();
        end
        step(); step(); step();
        chk("load_c4_data", {28'b0, Data_in}, 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", {31'b0, host_busy}, 32'd0);
        chk("mid_rst_strobes", {25'b0, Load, Sort, Send, Data_in}, 32'd0);
        chk("mid_rst_out", {28'b0, done, sorted_ok, sum_ok, err}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || host_busy) seen = 1;
        end
        chk("mid_rst_quiet", {31'b0, seen}, 32'd0);

        // Recovery after the abandoned job.
        run_job(32'h0F00A031, 0, 1'b0, 32'h000013AF, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
